// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS R/I-type instructions and streams them into an
// instruction memory, one word per two cycles, with fill count and full flag.
// Optional feature macro: INSTR_ENCODER_CHECKSUM_EN enables a running XOR of
// written words on chk_o; otherwise chk_o is tied to zero and no register exists.
module instr_encoder #(
   parameter int unsigned DEPTH = 128
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [2:0]  kind_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [15:0] imm_i,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic [10:0] count_o,
   output logic        full_o,
   output logic [31:0] chk_o
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 11;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0]   mem_data_q, mem_data_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    count_inc_c;
   logic [WORD_W-1:0]   word_c;

   // Encode the requested instruction into a 32-bit MIPS word.
   always_comb begin
      word_c = '0;
      case (kind_i)
         3'd0: word_c = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100000};
         3'd1: word_c = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100010};
         3'd2: word_c = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100100};
         3'd3: word_c = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100101};
         3'd4: word_c = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b101010};
         3'd5: word_c = {6'b001000, rs_i, rt_i, imm_i};
         3'd6: word_c = {6'b000100, rs_i, rt_i, imm_i};
         3'd7: word_c = {6'b001101, rs_i, rt_i, imm_i};
         default: word_c = '0;
      endcase
   end

   assign ready_o     = (state_q == IDLE) && !clear_i;
   assign mem_we_o    = (state_q == WRITE);
   assign mem_addr_o  = mem_addr_q;
   assign mem_data_o  = mem_data_q;
   assign count_o     = count_q;
   assign full_o      = (count_q == DEPTH_C);
   assign count_inc_c = count_q + CNT_W'(1);

   // Next-state, capture of the encoded word, and fill counter.
   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      count_d    = count_q;
      case (state_q)
         IDLE: begin
            if (clear_i) begin
               count_d = '0;
            end else if (valid_i) begin
               mem_data_d = word_c;
               mem_addr_d = WORD_W'({count_q, 2'b00});
               state_d    = WRITE;
            end
         end
         WRITE: begin
            if (clear_i) begin
               count_d = '0;
               state_d = IDLE;
            end else begin
               count_d = count_inc_c;
               state_d = (count_inc_c == DEPTH_C) ? FULL : IDLE;
            end
         end
         FULL: begin
            if (clear_i) begin
               count_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         count_q    <= count_d;
      end
   end

`ifdef INSTR_ENCODER_CHECKSUM_EN
   logic [WORD_W-1:0] chk_q, chk_d;

   // Fold each completed write into the checksum; clear wipes it.
   always_comb begin
      chk_d = chk_q;
      if (clear_i && (state_q != WRITE || 1'b1)) begin
         chk_d = '0;
      end else if (state_q == WRITE) begin
         chk_d = chk_q ^ mem_data_q;
      end
   end

   // Checksum register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         chk_q <= '0;
      end else begin
         chk_q <= chk_d;
      end
   end

   assign chk_o = chk_q;
`else
   assign chk_o = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4): directed scenarios followed
// by randomized traffic compared against a transaction-level reference model.
module tb_instr_encoder;

   localparam int unsigned DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_i, clear_i, valid_i, ready_o;
   logic [2:0]  kind_i;
   logic [4:0]  rs_i, rt_i, rd_i;
   logic [15:0] imm_i;
   logic        mem_we_o, full_o;
   logic [31:0] mem_addr_o, mem_data_o, chk_o;
   logic [10:0] count_o;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state: a write in flight, words written, checksum, last word.
   bit          m_busy;
   int unsigned m_count;
   logic [31:0] m_chk, m_addr, m_data;

   instr_encoder #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i),
      .ready_o(ready_o), .kind_i(kind_i), .rs_i(rs_i), .rt_i(rt_i),
      .rd_i(rd_i), .imm_i(imm_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .count_o(count_o),
      .full_o(full_o), .chk_o(chk_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] enc(input int unsigned kind, input int unsigned rs,
                                       input int unsigned rt, input int unsigned rd,
                                       input int unsigned imm);
      int unsigned functs[5] = '{32, 34, 36, 37, 42};
      int unsigned ops[3]    = '{8, 4, 13};
      if (kind < 5)
         return 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + functs[kind]);
      return 32'(ops[kind - 5] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, check ready, advance model and DUT, check outputs.
   task automatic cycle(input bit rst, input bit clr, input bit vld, input int unsigned kind,
                        input int unsigned rs, input int unsigned rt, input int unsigned rd,
                        input int unsigned imm);
      rst_i = rst; clear_i = clr; valid_i = vld;
      kind_i = 3'(kind); rs_i = 5'(rs); rt_i = 5'(rt); rd_i = 5'(rd); imm_i = 16'(imm);
      #1;
      check("ready", 32'(ready_o), 32'(!m_busy && m_count != DEPTH && !clr));
      if (rst) begin
         m_busy = 0; m_count = 0; m_chk = '0; m_addr = '0; m_data = '0;
      end else if (m_busy) begin
         m_busy = 0;
         if (clr) begin
            m_count = 0; m_chk = '0;
         end else begin
`ifdef INSTR_ENCODER_CHECKSUM_EN
            m_chk = m_chk ^ m_data;
`endif
            m_count++;
         end
      end else if (clr) begin
         m_count = 0; m_chk = '0;
      end else if (vld && m_count != DEPTH) begin
         m_busy = 1;
         m_data = enc(kind, rs, rt, rd, imm);
         m_addr = 32'(m_count * 4);
      end
      @(posedge clk_i);
      #1;
      check("we", 32'(mem_we_o), 32'(m_busy));
      check("addr", mem_addr_o, m_addr);
      check("data", mem_data_o, m_data);
      check("count", 32'(count_o), 32'(m_count));
      check("full", 32'(full_o), 32'(m_count == DEPTH));
      check("chk", chk_o, m_chk);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [31:0] exp_chk;
      logic [31:0] words[3];
      int          n_wr;
      m_busy = 0; m_count = 0; m_chk = '0; m_addr = '0; m_data = '0;
      rst_i = 1; clear_i = 0; valid_i = 0; kind_i = '0;
      rs_i = '0; rt_i = '0; rd_i = '0; imm_i = '0;
      @(posedge clk_i);
      #1;

      // Reset state
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      check("rst_count", 32'(count_o), 32'h0);
      check("rst_addr", mem_addr_o, 32'h0);
      check("rst_data", mem_data_o, 32'h0);
      idle();
      check("rst_ready", 32'(ready_o), 32'h1);

      // Single add
      cycle(0, 0, 1, 0, 1, 2, 3, 16'hABCD);
      check("add_we", 32'(mem_we_o), 32'h1);
      check("add_addr", mem_addr_o, 32'h0);
      check("add_data", mem_data_o, 32'h00221820);
      idle();
      check("add_count", 32'(count_o), 32'h1);

      // I-type sequence at consecutive addresses
      cycle(0, 1, 0, 0, 0, 0, 0, 0);
      words = '{32'h20220005, 32'h1022FFFF, 32'h340400FF};
      cycle(0, 0, 1, 5, 1, 2, 31, 16'h0005);
      check("addi_addr", mem_addr_o, 32'h0);
      check("addi_data", mem_data_o, words[0]);
      idle();
      cycle(0, 0, 1, 6, 1, 2, 7, 16'hFFFF);
      check("beq_addr", mem_addr_o, 32'h4);
      check("beq_data", mem_data_o, words[1]);
      idle();
      cycle(0, 0, 1, 7, 0, 4, 9, 16'h00FF);
      check("ori_addr", mem_addr_o, 32'h8);
      check("ori_data", mem_data_o, words[2]);
      idle();

      // Checksum of two words
      cycle(0, 1, 0, 0, 0, 0, 0, 0);
      check("clr_chk", chk_o, 32'h0);
      cycle(0, 0, 1, 0, 1, 2, 3, 0);
      idle();
      cycle(0, 0, 1, 5, 1, 2, 0, 16'h0005);
      idle();
`ifdef INSTR_ENCODER_CHECKSUM_EN
      exp_chk = 32'h20001825;
`else
      exp_chk = 32'h0;
`endif
      check("chk_pair", chk_o, exp_chk);

      // Fill to DEPTH with valid held high; fifth request must be ignored
      cycle(0, 1, 0, 0, 0, 0, 0, 0);
      n_wr = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(0, 0, 1, i % 8, i, i + 1, i + 2, i * 3);
         if (mem_we_o) begin
            check("fill_addr", mem_addr_o, 32'(n_wr * 4));
            n_wr++;
         end
      end
      check("fill_writes", 32'(n_wr), 32'd4);
      check("fill_full", 32'(full_o), 32'h1);
      check("fill_ready", 32'(ready_o), 32'h0);
      check("fill_count", 32'(count_o), 32'd4);

      // Clear with valid while FULL
      cycle(0, 1, 1, 0, 1, 1, 1, 0);
      check("unfull_count", 32'(count_o), 32'h0);
      check("unfull_full", 32'(full_o), 32'h0);

      // Reset during WRITE aborts the write
      cycle(0, 0, 1, 3, 4, 5, 6, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      check("abort_we", 32'(mem_we_o), 32'h0);
      check("abort_count", 32'(count_o), 32'h0);
      idle();
      check("abort_ready", 32'(ready_o), 32'h1);

      // Clear with valid in IDLE: no accept
      cycle(0, 1, 1, 2, 1, 1, 1, 0);
      check("clrv_we", 32'(mem_we_o), 32'h0);
      check("clrv_count", 32'(count_o), 32'h0);

      // Clear during WRITE: write completes, count drops to zero
      cycle(0, 0, 1, 1, 7, 8, 9, 0);
      cycle(0, 0, 1, 1, 7, 8, 9, 0);
      cycle(0, 0, 1, 4, 3, 2, 1, 0);
      check("wclr_we", 32'(mem_we_o), 32'h1);
      cycle(0, 1, 0, 0, 0, 0, 0, 0);
      check("wclr_count", 32'(count_o), 32'h0);
      check("wclr_we_after", 32'(mem_we_o), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 65535));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
